// File: rtl/mult_pipe_ext.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipe_ext
// Brief    : Pipelined shift-add multiplier, one partial-product stage per
//            multiplier bit, per-transaction signed/unsigned mode,
//            valid/ready backpressure, tag passthrough and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module mult_pipe_ext #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [N-1:0]     mult1,
  input  logic [M-1:0]     mult2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int W = N + M;

  // Stage 0 holds raw operands; stage k (1..M) holds the accumulator after
  // adding the partial product of multiplier bit k-1. Mode, multiplicand and
  // remaining multiplier bits are only needed up to stage M-1.
  logic [M:0]       vld;
  logic [M-1:0]     mode;
  logic [M-1:0]     mplier   [0:M-1];
  logic [W-1:0]     mcand    [0:M-1];
  logic [W-1:0]     acc      [0:M];
  logic [TAG_W-1:0] tag      [0:M];
  logic [W-1:0]     next_acc [1:M];

  logic advance;
  logic accept;

  // The whole pipe moves together; it only stalls when the output is held.
  assign advance   = !vld[M] || out_ready;
  assign in_ready  = advance && !flush && !rst;
  assign accept    = in_valid && in_ready;

  assign out_valid = vld[M];
  assign res       = acc[M];
  assign out_tag   = tag[M];
  assign busy      = |vld;

  // Partial-product adders. In signed mode the multiplier MSB carries
  // weight -2^(M-1), so its partial product is subtracted.
  for (genvar k = 1; k <= M; k++) begin : g_pp
    logic [W-1:0] pp;
    assign pp = mplier[k-1][0] ? mcand[k-1] : '0;
    if (k == M) begin : g_msb
      assign next_acc[k] = mode[k-1] ? (acc[k-1] - pp) : (acc[k-1] + pp);
    end else begin : g_low
      assign next_acc[k] = acc[k-1] + pp;
    end
  end

  // Pipeline registers: valid bits shift on advance; a stage's data only
  // follows its predecessor when that predecessor carries a transaction, so
  // bubbles never disturb the held output value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= '0;
      mode <= '0;
      for (int k = 0; k < M; k++) begin
        mplier[k] <= '0;
        mcand[k]  <= '0;
      end
      for (int k = 0; k <= M; k++) begin
        acc[k] <= '0;
        tag[k] <= '0;
      end
    end else begin
      if (flush) begin
        vld <= '0;
      end else if (advance) begin
        vld <= {vld[M-1:0], accept};
      end

      if (accept) begin
        mode[0]   <= in_signed;
        tag[0]    <= in_tag;
        mcand[0]  <= in_signed ? {{M{mult1[N-1]}}, mult1} : {{M{1'b0}}, mult1};
        mplier[0] <= mult2;
        acc[0]    <= '0;
      end

      if (advance && !flush) begin
        for (int k = 1; k < M; k++) begin
          if (vld[k-1]) begin
            mode[k]   <= mode[k-1];
            mcand[k]  <= mcand[k-1] << 1;
            mplier[k] <= mplier[k-1] >> 1;
          end
        end
        for (int k = 1; k <= M; k++) begin
          if (vld[k-1]) begin
            acc[k] <= next_acc[k];
            tag[k] <= tag[k-1];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
